// File: rtl/bp_be_stream_prefetch_engine.sv
// bp_be_stream_prefetch_engine
//
// Multi-stream stride prefetcher. Training events (load PC, effective
// address, signed byte stride, iteration count) allocate or retrain one of
// streams_p slots. Each slot walks its address sequence one stride per cycle
// and raises a prefetch.r dispatch packet whenever the walk enters a new D$
// block. Slots with a pending packet are arbitrated round-robin onto one
// dispatch port.
//
// Ports:
//   clk_i, reset_i        clock, synchronous active-high reset
//   v_i / ready_and_o     training event handshake
//   pc_i, eff_addr_i      load PC and demand effective address
//   stride_i              signed stride in bytes
//   loop_counter_i        maximum number of stride steps
//   flush_i               kill every stream
//   v_o / yumi_i          dispatch packet valid / consumed
//   dispatch_pkt_o        prefetch packet, MSB to LSB:
//                           v, nspec_v, pc, instr[31:0], rs1[dpath],
//                           pipe_mem_early_v, spec_w_v, score_v, dcache_r_v,
//                           mem_v, prefetch, irf_w_v, fu_op[5:0]
//   busy_o                at least one slot is not IDLE

module bp_be_stream_prefetch_engine #(
  parameter int vaddr_width_p        = 39,
  parameter int dcache_block_width_p = 512,
  parameter int dpath_width_gp       = 64,
  parameter int streams_p            = 4,
  parameter int loop_range_p         = 8,
  parameter int stride_width_p       = 8,
  localparam int block_offset_lp       = $clog2(dcache_block_width_p / 8),
  localparam int dispatch_pkt_width_lp = 2 + vaddr_width_p + 32 + dpath_width_gp + 13
) (
  input  logic                             clk_i,
  input  logic                             reset_i,
  input  logic                             v_i,
  output logic                             ready_and_o,
  input  logic [vaddr_width_p-1:0]         pc_i,
  input  logic [dpath_width_gp-1:0]        eff_addr_i,
  input  logic [stride_width_p-1:0]        stride_i,
  input  logic [loop_range_p-1:0]          loop_counter_i,
  input  logic                             flush_i,
  output logic                             v_o,
  output logic [dispatch_pkt_width_lp-1:0] dispatch_pkt_o,
  input  logic                             yumi_i,
  output logic                             busy_o
);

  localparam int idx_w_lp = (streams_p > 1) ? $clog2(streams_p) : 1;
  localparam int tag_w_lp = vaddr_width_p - block_offset_lp;

  localparam logic [6:0]  rv64_op_imm_op_lp  = 7'b0010011;
  localparam logic [5:0]  e_dcache_op_lb_lp  = 6'b000000;
  // prefetch.r: S-type layout, imm=0, rs2=1, rs1=0, funct3=110
  localparam logic [31:0] prefetch_instr_lp  = {7'b0, 5'b00001, 5'b0, 3'b110, 5'b0, rv64_op_imm_op_lp};
  // pipe_mem_early_v, spec_w_v, score_v, dcache_r_v, mem_v, prefetch, irf_w_v, fu_op
  localparam logic [12:0] prefetch_decode_lp = {6'b111111, 1'b0, e_dcache_op_lb_lp};

  typedef enum logic [1:0] {IDLE, WALK, SEND} state_e;

  function automatic logic signed [dpath_width_gp-1:0] sext_stride(input logic [stride_width_p-1:0] s);
    return {{(dpath_width_gp - stride_width_p){s[stride_width_p-1]}}, s};
  endfunction

  function automatic logic [dpath_width_gp-1:0] block_align(input logic [dpath_width_gp-1:0] a);
    return a & ~dpath_width_gp'((64'd1 << block_offset_lp) - 64'd1);
  endfunction

  state_e                            state_r  [streams_p];
  logic [vaddr_width_p-1:0]          pc_r     [streams_p];
  logic [dpath_width_gp-1:0]         addr_r   [streams_p];
  logic signed [dpath_width_gp-1:0]  stride_r [streams_p];
  logic [loop_range_p-1:0]           count_r  [streams_p];
  logic [tag_w_lp-1:0]               tag_r    [streams_p];

  logic [idx_w_lp-1:0] ptr_r;
  logic                hold_v_r;
  logic [idx_w_lp-1:0] hold_idx_r;

  logic [dpath_width_gp-1:0] addr_nxt [streams_p];
  logic [tag_w_lp-1:0]       tag_nxt  [streams_p];
  logic [streams_p-1:0]      step;
  logic [streams_p-1:0]      req;
  logic [streams_p-1:0]      not_idle;

  logic                match_any, idle_any;
  logic [idx_w_lp-1:0] match_idx, free_idx, alloc_idx;
  logic                accept, alloc;
  logic                rr_found;
  logic [idx_w_lp-1:0] rr_idx, grant_idx;
  logic                yumi_fire;

  // Slot status and next walk address
  always_comb begin
    for (int i = 0; i < streams_p; i++) begin
      addr_nxt[i] = addr_r[i] + $unsigned(stride_r[i]);
      tag_nxt[i]  = addr_nxt[i][vaddr_width_p-1:block_offset_lp];
      // A zero stride never leaves its block, so the slot retires at once.
      step[i]     = (state_r[i] == WALK) && (count_r[i] != '0) && (stride_r[i] != '0);
      req[i]      = (state_r[i] == SEND);
      not_idle[i] = (state_r[i] != IDLE);
    end
  end

  // Allocation: a PC hit retrains its slot, otherwise lowest free slot
  always_comb begin
    match_any = 1'b0;
    match_idx = '0;
    idle_any  = 1'b0;
    free_idx  = '0;
    for (int i = 0; i < streams_p; i++) begin
      if (!match_any && not_idle[i] && (pc_r[i] == pc_i)) begin
        match_any = 1'b1;
        match_idx = idx_w_lp'(i);
      end
    end
    for (int i = streams_p - 1; i >= 0; i--) begin
      if (!not_idle[i]) begin
        idle_any = 1'b1;
        free_idx = idx_w_lp'(i);
      end
    end
  end

  assign ready_and_o = idle_any | match_any;
  assign accept      = v_i & ready_and_o & ~flush_i;
  assign alloc       = accept & (loop_counter_i != '0);
  assign alloc_idx   = match_any ? match_idx : free_idx;

  // Round-robin pick starting at the pointer. A packet already on the port
  // keeps the grant so the output cannot change before it is consumed.
  always_comb begin
    int j;
    rr_found = 1'b0;
    rr_idx   = '0;
    for (int k = 0; k < streams_p; k++) begin
      j = int'(ptr_r) + k;
      if (j >= streams_p) j = j - streams_p;
      if (!rr_found && req[j]) begin
        rr_found = 1'b1;
        rr_idx   = idx_w_lp'(j);
      end
    end
    grant_idx = (hold_v_r && req[hold_idx_r]) ? hold_idx_r : rr_idx;
  end

  assign v_o            = |req;
  assign yumi_fire      = yumi_i & v_o;
  assign busy_o         = |not_idle;
  assign dispatch_pkt_o = {1'b1, 1'b1, pc_r[grant_idx], prefetch_instr_lp,
                           block_align(addr_r[grant_idx]), prefetch_decode_lp};

  // Control state: slot FSMs, arbiter pointer, grant hold
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      for (int i = 0; i < streams_p; i++) state_r[i] <= IDLE;
      ptr_r      <= '0;
      hold_v_r   <= 1'b0;
      hold_idx_r <= '0;
    end else begin
      if (yumi_fire) begin
        if (grant_idx == idx_w_lp'(streams_p - 1)) ptr_r <= '0;
        else                                       ptr_r <= grant_idx + 1'b1;
      end
      hold_v_r   <= v_o & ~yumi_i & ~flush_i;
      hold_idx_r <= grant_idx;
      for (int i = 0; i < streams_p; i++) begin
        if (flush_i) begin
          state_r[i] <= IDLE;
        end else if (alloc && (alloc_idx == idx_w_lp'(i))) begin
          // Retrain overrides a pending packet and a same-cycle yumi.
          state_r[i] <= WALK;
        end else begin
          case (state_r[i])
            WALK: begin
              if (!step[i])                   state_r[i] <= IDLE;
              else if (tag_nxt[i] != tag_r[i]) state_r[i] <= SEND;
            end
            SEND: begin
              if (yumi_fire && (grant_idx == idx_w_lp'(i))) state_r[i] <= WALK;
            end
            default: state_r[i] <= IDLE;
          endcase
        end
      end
    end
  end

  // Slot data: loaded on allocation, advanced on each walk step
  always_ff @(posedge clk_i) begin
    for (int i = 0; i < streams_p; i++) begin
      if (alloc && (alloc_idx == idx_w_lp'(i))) begin
        pc_r[i]     <= pc_i;
        addr_r[i]   <= eff_addr_i;
        stride_r[i] <= sext_stride(stride_i);
        count_r[i]  <= loop_counter_i;
        tag_r[i]    <= eff_addr_i[vaddr_width_p-1:block_offset_lp];
      end else if (step[i]) begin
        addr_r[i]   <= addr_nxt[i];
        count_r[i]  <= count_r[i] - 1'b1;
        tag_r[i]    <= tag_nxt[i];
      end
    end
  end

endmodule
